prefetch_burst_queue: RTL

PREFETCH_BURST_QUEUE -- requirements
Module: prefetch_burst_queue

---
 rtl/prefetch_burst_queue.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/prefetch_burst_queue.sv
// prefetch_burst_queue: circular queue of burst slots shared by prefetch and
// demand requests. Each slot holds one burst address, a demand "promise"
// counter and up to MAX_BURST data beats. Slave fills land at fillPtr in
// allocation order. The master drains the head slot once per outstanding
// demand. A stale prefetch at the head is popped when it blocks useful work.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   burstLen                   beats-1 per burst, latched while queue empty
//   allocValid/allocReady      allocation handshake
//   allocAddr, allocIsPref     burst address; 1 = prefetch, 0 = demand
//   hit                        allocAddr matches a valid slot (combinational)
//   fillValid/fillReady        slave read-data handshake
//   fillData, fillLast         slave beat and its last flag
//   outValid/outReady          master data handshake
//   outData, outLast           master beat and its last flag
//   prefCnt, pendCnt           slots with promise==0 / slots not fully filled
//   almostFull, empty          occupancy status
//   errorCode                  one-cycle error pulse (1 promise overflow,
//                              2 fillLast misplaced, 3 burstLen changed)
module prefetch_burst_queue #(
  parameter int unsigned LOG_SLOTS     = 2,
  parameter int unsigned LOG_MAX_BURST = 2,
  parameter int unsigned DATA_BITS     = 64,
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned PROMISE_WIDTH = 3,
  parameter int unsigned AF_SPACER     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LOG_MAX_BURST-1:0] burstLen,
  input  logic                     allocValid,
  output logic                     allocReady,
  input  logic [ADDR_BITS-1:0]     allocAddr,
  input  logic                     allocIsPref,
  output logic                     hit,
  input  logic                     fillValid,
  output logic                     fillReady,
  input  logic [DATA_BITS-1:0]     fillData,
  input  logic                     fillLast,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_BITS-1:0]     outData,
  output logic                     outLast,
  output logic [LOG_SLOTS:0]       prefCnt,
  output logic [LOG_SLOTS:0]       pendCnt,
  output logic                     almostFull,
  output logic                     empty,
  output logic [1:0]               errorCode
);

  localparam int unsigned NUM_SLOTS = 1 << LOG_SLOTS;
  localparam int unsigned MAX_BURST = 1 << LOG_MAX_BURST;
  localparam int unsigned CNT_W     = LOG_SLOTS + 1;
  localparam logic [PROMISE_WIDTH-1:0] PROMISE_MAX = {PROMISE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_PROMISE   = 2'd1,
    ERR_FILL_LAST = 2'd2,
    ERR_BURST_LEN = 2'd3
  } errCode_t;

  // Slot state
  logic [NUM_SLOTS-1:0]     slotValid;
  logic [ADDR_BITS-1:0]     slotAddr    [NUM_SLOTS];
  logic [PROMISE_WIDTH-1:0] slotPromise [NUM_SLOTS];
  logic [MAX_BURST-1:0]     beatValid   [NUM_SLOTS];
  logic [DATA_BITS-1:0]     beatData    [NUM_SLOTS][MAX_BURST];

  // Pointers and beat counters
  logic [LOG_SLOTS-1:0]     headPtr;
  logic [LOG_SLOTS-1:0]     tailPtr;
  logic [LOG_SLOTS-1:0]     fillPtr;
  logic [LOG_MAX_BURST-1:0] fillBeat;
  logic [LOG_MAX_BURST-1:0] outBeat;
  logic [LOG_MAX_BURST-1:0] burstLenQ;
  logic [1:0]               errorReg;

  // Decode
  logic                 hitAny;
  logic [LOG_SLOTS-1:0] hitIdx;
  logic [CNT_W-1:0]     validCount;
  logic [CNT_W-1:0]     prefCount;
  logic [CNT_W-1:0]     pendCount;
  logic                 queueEmpty;
  logic                 queueFull;
  logic                 allocFire;
  logic                 demandHit;
  logic                 allocMiss;
  logic                 fillFire;
  logic                 fillAtLast;
  logic                 outFire;
  logic                 drainDone;
  logic [LOG_SLOTS-1:0] nextIdx;
  logic                 headDemandHit;
  logic                 popHead;
  logic                 promiseOverflow;
  errCode_t             errNext;

  // Associative match and occupancy counts over all slots
  always_comb begin
    hitAny     = 1'b0;
    hitIdx     = '0;
    validCount = '0;
    prefCount  = '0;
    pendCount  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slotValid[i]) begin
        validCount = validCount + CNT_W'(1);
        if (slotAddr[i] == allocAddr) begin
          hitAny = 1'b1;
          hitIdx = LOG_SLOTS'(i);
        end
        if (slotPromise[i] == '0) prefCount = prefCount + CNT_W'(1);
        if (!beatValid[i][burstLenQ]) pendCount = pendCount + CNT_W'(1);
      end
    end
  end

  // Handshakes, pop decision and error selection
  always_comb begin
    queueEmpty = (validCount == '0);
    queueFull  = (validCount == CNT_W'(NUM_SLOTS));

    allocFire = allocValid & (hitAny | ~queueFull);
    demandHit = allocFire & hitAny & ~allocIsPref;
    allocMiss = allocFire & ~hitAny;

    // A slot is complete once its final beat (index burstLenQ) is valid,
    // because beats are always filled in order.
    fillFire   = fillValid & slotValid[fillPtr] & ~beatValid[fillPtr][burstLenQ];
    fillAtLast = (fillBeat == burstLenQ);

    outFire   = outReady & slotValid[headPtr] & (slotPromise[headPtr] != '0)
              & beatValid[headPtr][outBeat];
    drainDone = outFire & (outBeat == burstLenQ);

    nextIdx       = headPtr + LOG_SLOTS'(1);
    headDemandHit = demandHit & (hitIdx == headPtr);

    // Drop an unclaimed head only when it stands in the way of real demand
    // behind it or of a new allocation into a full queue.
    popHead = slotValid[headPtr] && (slotPromise[headPtr] == '0)
           && beatValid[headPtr][burstLenQ] && !drainDone && !headDemandHit
           && ((slotValid[nextIdx] && (slotPromise[nextIdx] != '0)) || queueFull);

    // A concurrent last-beat drain cancels the increment, so no overflow then.
    promiseOverflow = demandHit && (slotPromise[hitIdx] == PROMISE_MAX)
                   && !(drainDone && (hitIdx == headPtr));

    errNext = ERR_NONE;
    if (promiseOverflow)                                 errNext = ERR_PROMISE;
    else if (fillFire && (fillLast != fillAtLast))       errNext = ERR_FILL_LAST;
    else if (!queueEmpty && (burstLen != burstLenQ))     errNext = ERR_BURST_LEN;
  end

  // Control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slotValid <= '0;
      headPtr   <= '0;
      tailPtr   <= '0;
      fillPtr   <= '0;
      fillBeat  <= '0;
      outBeat   <= '0;
      burstLenQ <= '0;
      errorReg  <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slotAddr[i]    <= '0;
        slotPromise[i] <= '0;
        beatValid[i]   <= '0;
      end
    end else begin
      errorReg <= errNext;
      if (queueEmpty) burstLenQ <= burstLen;
      if (allocMiss)  tailPtr   <= tailPtr + LOG_SLOTS'(1);
      if (popHead)    headPtr   <= nextIdx;

      if (fillFire) begin
        if (fillAtLast) begin
          fillBeat <= '0;
          fillPtr  <= fillPtr + LOG_SLOTS'(1);
        end else begin
          fillBeat <= fillBeat + LOG_MAX_BURST'(1);
        end
      end

      if (outFire) outBeat <= drainDone ? '0 : outBeat + LOG_MAX_BURST'(1);

      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (popHead && (headPtr == LOG_SLOTS'(i))) begin
          slotValid[i] <= 1'b0;
          beatValid[i] <= '0;
        end
        if (allocMiss && (tailPtr == LOG_SLOTS'(i))) begin
          slotValid[i]   <= 1'b1;
          slotAddr[i]    <= allocAddr;
          slotPromise[i] <= allocIsPref ? '0 : PROMISE_WIDTH'(1);
          beatValid[i]   <= '0;
        end
        if (fillFire && (fillPtr == LOG_SLOTS'(i))) beatValid[i][fillBeat] <= 1'b1;

        // Hit and last-beat drain on the same slot cancel each other.
        if (demandHit && (hitIdx == LOG_SLOTS'(i))) begin
          if (!(drainDone && (headPtr == LOG_SLOTS'(i))) && (slotPromise[i] != PROMISE_MAX))
            slotPromise[i] <= slotPromise[i] + PROMISE_WIDTH'(1);
        end else if (drainDone && (headPtr == LOG_SLOTS'(i))) begin
          slotPromise[i] <= slotPromise[i] - PROMISE_WIDTH'(1);
        end
      end
    end
  end

  // Beat storage; contents are qualified by beatValid, so no reset needed
  always_ff @(posedge clk) begin
    if (fillFire) beatData[fillPtr][fillBeat] <= fillData;
  end

  assign hit        = hitAny;
  assign allocReady = hitAny | ~queueFull;
  assign fillReady  = slotValid[fillPtr] & ~beatValid[fillPtr][burstLenQ];
  assign outValid   = slotValid[headPtr] & (slotPromise[headPtr] != '0)
                    & beatValid[headPtr][outBeat];
  assign outData    = beatData[headPtr][outBeat];
  assign outLast    = (outBeat == burstLenQ);
  assign prefCnt    = prefCount;
  assign pendCnt    = pendCount;
  assign empty      = queueEmpty;
  assign almostFull = !queueEmpty
                   && ((CNT_W'(NUM_SLOTS) - validCount) <= CNT_W'(AF_SPACER));
  assign errorCode  = errorReg;

endmodule
